ascon_aead_sequencer: RTL

Control FSM for the Ascon-AEAD encryption datapath. It drives one shared Ascon permutation core and the state-update muxes through the phases in order: initialization, associated-data absorption, domain separation, plaintext absorption, finalization and tag release. It holds no cipher state; it emits one-cycle control pulses, block indices and padding information to the datapath that owns the 320-bit state.

---
 rtl/ascon_pkg.sv | 53 +++++
 rtl/ascon_blk_cnt.sv | 60 ++++++
 rtl/ascon_aead_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared types, constants and elaboration-time helpers for the Ascon-AEAD
// encryption sequencer: FSM state encoding, default round counts, IV, and the
// block-count / padding derivations from (rate, AD length, PT length).
package ascon_pkg;

  localparam int unsigned K_BITS   = 128;
  localparam int unsigned R_BITS   = 64;
  localparam int unsigned A_ROUNDS = 12;
  localparam int unsigned B_ROUNDS = 6;
  localparam int unsigned BLK_W    = 8;

  // Ascon-128 IV: k=128, r=64, a=12, b=6
  localparam logic [63:0] ASCON_IV = 64'h8040_0c06_0000_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_LOAD,
    S_INIT_PERM,
    S_INIT_KEY,
    S_AD_ABS,
    S_AD_PERM,
    S_DOMSEP,
    S_PT_ABS,
    S_PT_PERM,
    S_FIN_KEY,
    S_FIN_PERM,
    S_TAG
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << res) < 64'(v)) res = res + 1;
    end
    return res;
  endfunction

  // AD is skipped entirely when empty; otherwise the final block is padded
  function automatic int unsigned n_ad(input int unsigned r, input int unsigned l);
    return (l == 0) ? 0 : (l / r + 1);
  endfunction

  // PT always has at least one (possibly pure-padding) block
  function automatic int unsigned n_pt(input int unsigned r, input int unsigned y);
    return y / r + 1;
  endfunction

  function automatic int unsigned last_bits_of(input int unsigned r, input int unsigned len);
    return len % r;
  endfunction

endpackage

// File: rtl/ascon_blk_cnt.sv
// Block counter shared by the AD and PT phases.
//   ld_i    : idx <= 0, block count <= n_blk_i
//   clr_i   : idx <= 0, block count <= 0 (has priority)
//   inc_i   : idx <= idx + 1
//   idx_o          : current block index (registered)
//   is_last_o      : idx_o is the final block of the loaded count (registered)
//   is_last_nxt_c  : is_last value that will hold after the coming edge
module ascon_blk_cnt
  import ascon_pkg::*;
#(
  parameter int unsigned CNT_W = BLK_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] n_blk_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] idx_o,
  output logic             is_last_o,
  output logic             is_last_nxt_c
);

  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             last_q;

  // Next index / count; clear dominates load dominates increment
  always_comb begin
    idx_d = idx_q;
    n_d   = n_q;
    if (clr_i) begin
      idx_d = '0;
      n_d   = '0;
    end else if (ld_i) begin
      idx_d = '0;
      n_d   = n_blk_i;
    end else if (inc_i) begin
      idx_d = idx_q + CNT_W'(1);
    end
    // n_d==0 only while cleared, where the compare can never match idx_d==0
    is_last_nxt_c = (n_d != '0) && (idx_d == n_d - CNT_W'(1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      n_q    <= '0;
      last_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      n_q    <= n_d;
      last_q <= is_last_nxt_c;
    end
  end

  assign idx_o     = idx_q;
  assign is_last_o = last_q;

endmodule

// File: rtl/ascon_aead_sequencer.sv
// Ascon-AEAD encryption control FSM. Steps a shared permutation core and the
// state-update muxes through init, AD absorption, domain separation, PT
// absorption, finalization and tag release. All outputs are registered.
//   start_i / abort_i   : begin (IDLE only) / cancel back to IDLE
//   perm_done_i         : completion pulse from the permutation core
//   perm_start_o, perm_rounds_o : launch pulse and round count (a or b)
//   ld_init_o .. tag_valid_o    : one-cycle datapath operation pulses
//   last_blk_o, last_bits_o, blk_idx_o : block position / padding info
//   busy_o              : high outside IDLE
module ascon_aead_sequencer
  import ascon_pkg::*;
#(
  parameter  int unsigned R_BITS_P = R_BITS,
  parameter  int unsigned A_RND    = A_ROUNDS,
  parameter  int unsigned B_RND    = B_ROUNDS,
  parameter  int unsigned L_BITS   = 40,
  parameter  int unsigned Y_BITS   = 40,
  localparam int unsigned LB_W     = clog2(R_BITS_P) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             perm_done_i,
  output logic             perm_start_o,
  output logic [3:0]       perm_rounds_o,
  output logic             ld_init_o,
  output logic             xor_key_init_o,
  output logic             absorb_ad_o,
  output logic             dom_sep_o,
  output logic             absorb_pt_o,
  output logic             xor_key_fin_o,
  output logic             last_blk_o,
  output logic [LB_W-1:0]  last_bits_o,
  output logic [BLK_W-1:0] blk_idx_o,
  output logic             busy_o,
  output logic             tag_valid_o
);

  localparam logic [BLK_W-1:0] N_AD_C  = BLK_W'(n_ad(R_BITS_P, L_BITS));
  localparam logic [BLK_W-1:0] N_PT_C  = BLK_W'(n_pt(R_BITS_P, Y_BITS));
  localparam logic [LB_W-1:0]  LB_AD_C = LB_W'(last_bits_of(R_BITS_P, L_BITS));
  localparam logic [LB_W-1:0]  LB_PT_C = LB_W'(last_bits_of(R_BITS_P, Y_BITS));

  state_e           state_q, state_d;
  logic             perm_start_q, perm_start_d;
  logic [3:0]       perm_rounds_q, perm_rounds_d;
  logic             ld_init_q, xor_key_init_q, absorb_ad_q, dom_sep_q;
  logic             absorb_pt_q, xor_key_fin_q, tag_valid_q, busy_q;
  logic             last_blk_q, last_blk_d;
  logic [LB_W-1:0]  last_bits_q, last_bits_d;

  logic             cnt_clr, cnt_ld, cnt_inc;
  logic [BLK_W-1:0] cnt_n;
  logic             cnt_last, cnt_last_nxt;
  logic             done_ok;
  logic             is_perm_d;

  ascon_blk_cnt #(.CNT_W(BLK_W)) u_blk_cnt (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clr_i         (cnt_clr),
    .ld_i          (cnt_ld),
    .n_blk_i       (cnt_n),
    .inc_i         (cnt_inc),
    .idx_o         (blk_idx_o),
    .is_last_o     (cnt_last),
    .is_last_nxt_c (cnt_last_nxt)
  );

  // A completion pulse coinciding with the launch cycle is stale
  assign done_ok = perm_done_i && !perm_start_q;

  // Next state, counter controls and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_ld  = 1'b0;
    cnt_inc = 1'b0;
    cnt_n   = '0;

    unique case (state_q)
      S_IDLE:      if (start_i) state_d = S_INIT_LOAD;
      S_INIT_LOAD: state_d = S_INIT_PERM;
      S_INIT_PERM: if (done_ok) state_d = S_INIT_KEY;
      S_INIT_KEY: begin
        if (N_AD_C != '0) begin
          state_d = S_AD_ABS;
          cnt_ld  = 1'b1;
          cnt_n   = N_AD_C;
        end else begin
          state_d = S_DOMSEP;
        end
      end
      S_AD_ABS:    state_d = S_AD_PERM;
      S_AD_PERM: begin
        if (done_ok) begin
          if (cnt_last) begin
            state_d = S_DOMSEP;
            cnt_clr = 1'b1;
          end else begin
            state_d = S_AD_ABS;
            cnt_inc = 1'b1;
          end
        end
      end
      S_DOMSEP: begin
        state_d = S_PT_ABS;
        cnt_ld  = 1'b1;
        cnt_n   = N_PT_C;
      end
      // The final PT block goes straight to finalization, no b-round permutation
      S_PT_ABS: begin
        if (cnt_last) begin
          state_d = S_FIN_KEY;
          cnt_clr = 1'b1;
        end else begin
          state_d = S_PT_PERM;
        end
      end
      S_PT_PERM: begin
        if (done_ok) begin
          state_d = S_PT_ABS;
          cnt_inc = 1'b1;
        end
      end
      S_FIN_KEY:   state_d = S_FIN_PERM;
      S_FIN_PERM:  if (done_ok) state_d = S_TAG;
      S_TAG:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
      cnt_ld  = 1'b0;
      cnt_inc = 1'b0;
    end

    is_perm_d = (state_d == S_INIT_PERM) || (state_d == S_AD_PERM) ||
                (state_d == S_PT_PERM)   || (state_d == S_FIN_PERM);
    // Launch only on entry; every PERM state is entered from a different state
    perm_start_d = is_perm_d && (state_d != state_q);

    perm_rounds_d = 4'd0;
    if ((state_d == S_INIT_PERM) || (state_d == S_FIN_PERM)) perm_rounds_d = 4'(A_RND);
    if ((state_d == S_AD_PERM) || (state_d == S_PT_PERM))    perm_rounds_d = 4'(B_RND);

    last_blk_d  = ((state_d == S_AD_ABS) || (state_d == S_PT_ABS)) && cnt_last_nxt;
    last_bits_d = '0;
    if (last_blk_d) last_bits_d = (state_d == S_AD_ABS) ? LB_AD_C : LB_PT_C;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      perm_start_q   <= 1'b0;
      perm_rounds_q  <= 4'd0;
      ld_init_q      <= 1'b0;
      xor_key_init_q <= 1'b0;
      absorb_ad_q    <= 1'b0;
      dom_sep_q      <= 1'b0;
      absorb_pt_q    <= 1'b0;
      xor_key_fin_q  <= 1'b0;
      tag_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      last_blk_q     <= 1'b0;
      last_bits_q    <= '0;
    end else begin
      state_q        <= state_d;
      perm_start_q   <= perm_start_d;
      perm_rounds_q  <= perm_rounds_d;
      ld_init_q      <= (state_d == S_INIT_LOAD);
      xor_key_init_q <= (state_d == S_INIT_KEY);
      absorb_ad_q    <= (state_d == S_AD_ABS);
      dom_sep_q      <= (state_d == S_DOMSEP);
      absorb_pt_q    <= (state_d == S_PT_ABS);
      xor_key_fin_q  <= (state_d == S_FIN_KEY);
      tag_valid_q    <= (state_d == S_TAG);
      busy_q         <= (state_d != S_IDLE);
      last_blk_q     <= last_blk_d;
      last_bits_q    <= last_bits_d;
    end
  end

  assign perm_start_o   = perm_start_q;
  assign perm_rounds_o  = perm_rounds_q;
  assign ld_init_o      = ld_init_q;
  assign xor_key_init_o = xor_key_init_q;
  assign absorb_ad_o    = absorb_ad_q;
  assign dom_sep_o      = dom_sep_q;
  assign absorb_pt_o    = absorb_pt_q;
  assign xor_key_fin_o  = xor_key_fin_q;
  assign tag_valid_o    = tag_valid_q;
  assign busy_o         = busy_q;
  assign last_blk_o     = last_blk_q;
  assign last_bits_o    = last_bits_q;

endmodule
